// File: rtl/lieat_exu_disp.sv
`default_nettype none
// ============================================================================
// Module   : lieat_exu_disp
// Brief    : Decode-to-execute dispatch with RAW/WAW scoreboard and 5-way steer.
// Revision : 1.0
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RGIDX_SIZE
`define RGIDX_SIZE 5
`endif
`ifndef INFOBUS_OP
`define INFOBUS_OP 2:0
`endif

module lieat_exu_disp (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [`XLEN-1:0]       i_pc,
  input  logic [`XLEN-1:0]       i_infobus,
  input  logic [`XLEN-1:0]       i_imm,
  input  logic [`RGIDX_SIZE-1:0] i_rs1,
  input  logic [`RGIDX_SIZE-1:0] i_rs2,
  input  logic [`RGIDX_SIZE-1:0] i_rd,
  input  logic                   i_rs1en,
  input  logic                   i_rs2en,
  input  logic                   i_rdwen,
  input  logic                   i_ilgl,
  output logic [4:0]             o_valid,
  input  logic [4:0]             o_ready,
  output logic [`XLEN-1:0]       o_pc,
  output logic [`XLEN-1:0]       o_infobus,
  output logic [`XLEN-1:0]       o_imm,
  output logic [`RGIDX_SIZE-1:0] o_rs1,
  output logic [`RGIDX_SIZE-1:0] o_rs2,
  output logic [`RGIDX_SIZE-1:0] o_rd,
  output logic                   o_rdwen,
  output logic                   o_ilgl,
  input  logic                   wbck_valid,
  input  logic [`RGIDX_SIZE-1:0] wbck_rd,
  input  logic                   flush,
  output logic [31:0]            o_stall_cnt
);

  localparam logic [2:0] c_op_alu = 3'd0;
  localparam logic [2:0] c_op_bjp = 3'd1;
  localparam logic [2:0] c_op_lsu = 3'd2;
  localparam logic [2:0] c_op_csr = 3'd3;
  localparam logic [2:0] c_op_mul = 3'd4;
  localparam logic [4:0] c_chan_csr = 5'b01000;

  logic [31:0]            pend_q, pend_d;
  logic                   held_vld_q, held_vld_d;
  logic [4:0]             chan_q, chan_d;
  logic [`XLEN-1:0]       pc_q, pc_d;
  logic [`XLEN-1:0]       infobus_q, infobus_d;
  logic [`XLEN-1:0]       imm_q, imm_d;
  logic [`RGIDX_SIZE-1:0] rs1_q, rs1_d;
  logic [`RGIDX_SIZE-1:0] rs2_q, rs2_d;
  logic [`RGIDX_SIZE-1:0] rd_q, rd_d;
  logic                   rdwen_q, rdwen_d;
  logic                   ilgl_q, ilgl_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  logic [2:0]             w_op;
  logic                   w_op_ilgl;
  logic                   w_ilgl;
  logic [4:0]             w_chan;
  logic                   w_hazard;
  logic                   w_out_fire;
  logic                   w_accept;

  assign w_op = i_infobus[`INFOBUS_OP];

  // Only the registered scoreboard is consulted; a same-cycle writeback does not bypass.
  assign w_hazard   = i_valid & ((i_rs1en & pend_q[i_rs1]) |
                                 (i_rs2en & pend_q[i_rs2]) |
                                 (i_rdwen & pend_q[i_rd]));
  assign w_out_fire = held_vld_q & (|(chan_q & o_ready));
  assign i_ready    = (~held_vld_q | w_out_fire) & ~w_hazard & ~flush;
  assign w_accept   = i_valid & i_ready;

  always_comb begin
    w_op_ilgl = 1'b0;
    w_chan    = c_chan_csr;
    case (w_op)
      c_op_alu: w_chan = 5'b00001;
      c_op_bjp: w_chan = 5'b00010;
      c_op_lsu: w_chan = 5'b00100;
      c_op_csr: w_chan = 5'b01000;
      c_op_mul: w_chan = 5'b10000;
      default:  w_op_ilgl = 1'b1;
    endcase
    w_ilgl = i_ilgl | w_op_ilgl;
    if (w_ilgl) begin
      w_chan = c_chan_csr;
    end
  end

  always_comb begin
    held_vld_d  = held_vld_q;
    chan_d      = chan_q;
    pc_d        = pc_q;
    infobus_d   = infobus_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rdwen_d     = rdwen_q;
    ilgl_d      = ilgl_q;
    pend_d      = pend_q;
    stall_cnt_d = stall_cnt_q;

    // Flush wins over fire; i_ready is already low so no accept coincides.
    if (flush) begin
      held_vld_d = 1'b0;
    end else if (w_accept) begin
      held_vld_d = 1'b1;
      chan_d     = w_chan;
      pc_d       = i_pc;
      infobus_d  = i_infobus;
      imm_d      = i_imm;
      rs1_d      = i_rs1;
      rs2_d      = i_rs2;
      rd_d       = i_rd;
      rdwen_d    = i_rdwen & ~w_ilgl;
      ilgl_d     = w_ilgl;
    end else if (w_out_fire) begin
      held_vld_d = 1'b0;
    end

    // Clears first so a simultaneous accept on the same index keeps the bit set.
    if (wbck_valid && (wbck_rd != '0)) begin
      pend_d[wbck_rd] = 1'b0;
    end
    if (flush && held_vld_q && rdwen_q) begin
      pend_d[rd_q] = 1'b0;
    end
    if (w_accept && i_rdwen && !w_ilgl && (i_rd != '0)) begin
      pend_d[i_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;

    if (w_hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_vld_q  <= 1'b0;
      chan_q      <= '0;
      pc_q        <= '0;
      infobus_q   <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rdwen_q     <= 1'b0;
      ilgl_q      <= 1'b0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      held_vld_q  <= held_vld_d;
      chan_q      <= chan_d;
      pc_q        <= pc_d;
      infobus_q   <= infobus_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rdwen_q     <= rdwen_d;
      ilgl_q      <= ilgl_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_valid     = held_vld_q ? chan_q : 5'b00000;
  assign o_pc        = pc_q;
  assign o_infobus   = infobus_q;
  assign o_imm       = imm_q;
  assign o_rs1       = rs1_q;
  assign o_rs2       = rs2_q;
  assign o_rd        = rd_q;
  assign o_rdwen     = rdwen_q;
  assign o_ilgl      = ilgl_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lieat_exu_disp.sv
`default_nettype none
// ============================================================================
// Module   : tb_lieat_exu_disp
// Brief    : Scoreboard bench for the dispatch stage.
// Revision : 1.0
// ============================================================================

module tb_lieat_exu_disp;

  localparam logic [2:0] c_op_alu = 3'd0;
  localparam logic [2:0] c_op_bjp = 3'd1;
  localparam logic [2:0] c_op_lsu = 3'd2;
  localparam logic [2:0] c_op_mul = 3'd4;
  localparam logic [2:0] c_op_bad = 3'd6;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_pc, i_infobus, i_imm;
  logic [4:0]  i_rs1, i_rs2, i_rd;
  logic        i_rs1en, i_rs2en, i_rdwen, i_ilgl;
  logic [4:0]  o_valid;
  logic [4:0]  o_ready;
  logic [31:0] o_pc, o_infobus, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic        o_rdwen, o_ilgl;
  logic        wbck_valid;
  logic [4:0]  wbck_rd;
  logic        flush;
  logic [31:0] o_stall_cnt;

  typedef struct {
    logic [4:0]  chan;
    logic [31:0] pc;
    logic [31:0] infobus;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rdwen;
    logic        ilgl;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_stall = 32'd0;
  logic        busy;

  lieat_exu_disp dut (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_pc(i_pc), .i_infobus(i_infobus), .i_imm(i_imm),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_rs1en(i_rs1en), .i_rs2en(i_rs2en), .i_rdwen(i_rdwen), .i_ilgl(i_ilgl),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_pc(o_pc), .o_infobus(o_infobus), .o_imm(o_imm),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_rdwen(o_rdwen), .o_ilgl(o_ilgl),
    .wbck_valid(wbck_valid), .wbck_rd(wbck_rd),
    .flush(flush), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clock = ~clock;

  // Pops on every fire, discards on flush, and checks the held payload is stable.
  logic        prev_hold = 1'b0;
  logic [4:0]  prev_valid;
  logic [31:0] prev_pc, prev_imm;
  logic [4:0]  prev_rd;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_checks++;
        if (o_valid !== prev_valid || o_pc !== prev_pc || o_imm !== prev_imm || o_rd !== prev_rd) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b pc=%h imm=%h rd=%0d, required valid=%b pc=%h imm=%h rd=%0d",
                   o_valid, o_pc, o_imm, o_rd, prev_valid, prev_pc, prev_imm, prev_rd);
        end
      end
      prev_hold = 1'b0;
      if (flush) begin
        if ((|o_valid) && sb_q.size() > 0) void'(sb_q.pop_front());
      end else if ((o_valid & o_ready) != 5'b0) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_fire: got fire with valid=%b pc=%h, required no pending entry", o_valid, o_pc);
        end else begin
          e = sb_q.pop_front();
          if (o_valid !== e.chan || o_pc !== e.pc || o_infobus !== e.infobus || o_imm !== e.imm ||
              o_rs1 !== e.rs1 || o_rs2 !== e.rs2 || o_rd !== e.rd || o_rdwen !== e.rdwen || o_ilgl !== e.ilgl) begin
            n_fail++;
            $display("FAIL sb_payload: got valid=%b pc=%h ib=%h imm=%h rs1=%0d rs2=%0d rd=%0d rdwen=%b ilgl=%b, required valid=%b pc=%h ib=%h imm=%h rs1=%0d rs2=%0d rd=%0d rdwen=%b ilgl=%b",
                     o_valid, o_pc, o_infobus, o_imm, o_rs1, o_rs2, o_rd, o_rdwen, o_ilgl,
                     e.chan, e.pc, e.infobus, e.imm, e.rs1, e.rs2, e.rd, e.rdwen, e.ilgl);
          end
        end
      end else if (|o_valid) begin
        prev_hold  = 1'b1;
        prev_valid = o_valid;
        prev_pc    = o_pc;
        prev_imm   = o_imm;
        prev_rd    = o_rd;
      end
      if (i_valid && i_ready) begin
        e.ilgl    = i_ilgl || (i_infobus[2:0] > 3'd4);
        e.chan    = e.ilgl ? 5'b01000 : (5'b00001 << i_infobus[2:0]);
        e.pc      = i_pc;
        e.infobus = i_infobus;
        e.imm     = i_imm;
        e.rs1     = i_rs1;
        e.rs2     = i_rs2;
        e.rd      = i_rd;
        e.rdwen   = i_rdwen & ~e.ilgl;
        sb_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    i_valid = 1'b0; i_pc = '0; i_infobus = '0; i_imm = '0;
    i_rs1 = '0; i_rs2 = '0; i_rd = '0;
    i_rs1en = 1'b0; i_rs2en = 1'b0; i_rdwen = 1'b0; i_ilgl = 1'b0;
    wbck_valid = 1'b0; wbck_rd = '0; flush = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [2:0] op,
                      input logic [4:0] rs1, input logic rs1en,
                      input logic [4:0] rs2, input logic rs2en,
                      input logic [4:0] rd, input logic rdwen, input logic ilgl);
    i_valid = 1'b1; i_pc = pc; i_infobus = {pc[28:0], op}; i_imm = ~pc;
    i_rs1 = rs1; i_rs1en = rs1en; i_rs2 = rs2; i_rs2en = rs2en;
    i_rd = rd; i_rdwen = rdwen; i_ilgl = ilgl;
  endtask

  // Presents a read of idx for 1 ns only, so nothing is accepted or counted as a stall.
  task automatic probe(input logic [4:0] idx, output logic is_busy);
    send(32'h0, c_op_alu, idx, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    is_busy = ~i_ready;
    idle_in();
  endtask

  task automatic test_reset();
    idle_in();
    o_ready = 5'h1f;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 00000", o_valid); end
    n_checks++;
    if ({o_pc, o_infobus, o_imm, o_rs1, o_rs2, o_rd, o_rdwen, o_ilgl} !== '0) begin
      n_fail++; $display("FAIL reset_payload: got pc=%h ib=%h imm=%h rd=%0d, required all zero", o_pc, o_infobus, o_imm, o_rd);
    end
    n_checks++;
    if (o_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d, required 0", o_stall_cnt); end
    n_checks++;
    if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", i_ready); end
  endtask

  task automatic test_back_to_back();
    step(); send(32'h100, c_op_alu, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b, required 1", i_ready); end
    step(); send(32'h104, c_op_alu, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b00001 || o_rd !== 5'd3 || i_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_cycle1: got valid=%b rd=%0d ready=%b, required 00001 3 1", o_valid, o_rd, i_ready);
    end
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b00001 || o_rd !== 5'd4) begin
      n_fail++; $display("FAIL b2b_cycle2: got valid=%b rd=%0d, required 00001 4", o_valid, o_rd);
    end
    step();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b0) begin n_fail++; $display("FAIL b2b_drain: got %b, required 00000", o_valid); end
    step(); probe(5'd3, busy);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_pend3: got busy=%b, required 1", busy); end
    step(); probe(5'd4, busy);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_pend4: got busy=%b, required 1", busy); end
    @(negedge clock);
    n_checks++;
    if (o_stall_cnt !== exp_stall) begin n_fail++; $display("FAIL b2b_stall: got %0d, required %0d", o_stall_cnt, exp_stall); end
    step(); wbck_valid = 1'b1; wbck_rd = 5'd3;
    step(); wbck_rd = 5'd4;
    step(); wbck_valid = 1'b0;
  endtask

  task automatic test_raw_stall();
    step(); send(32'h200, c_op_lsu, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b1) begin n_fail++; $display("FAIL raw_load_ready: got %b, required 1", i_ready); end
    step(); send(32'h204, c_op_alu, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin wbck_valid = 1'b1; wbck_rd = 5'd5; end
      @(negedge clock);
      n_checks++;
      if (i_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_%0d: got ready=%b, required 0", c, i_ready); end
      step();
    end
    wbck_valid = 1'b0;
    exp_stall = exp_stall + 32'd3;
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b1 || o_stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL raw_release: got ready=%b stall=%0d, required 1 %0d", i_ready, o_stall_cnt, exp_stall);
    end
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b00001 || o_rd !== 5'd8 || o_stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL raw_dispatch: got valid=%b rd=%0d stall=%0d, required 00001 8 %0d", o_valid, o_rd, o_stall_cnt, exp_stall);
    end
    step(); wbck_valid = 1'b1; wbck_rd = 5'd8;
    step(); wbck_valid = 1'b0;
  endtask

  task automatic test_mul_backpressure();
    o_ready = 5'b01111;
    step(); send(32'h300, c_op_mul, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready0: got %b, required 1", i_ready); end
    step(); send(32'h304, c_op_alu, 5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_checks++;
      if (o_valid !== 5'b10000 || o_pc !== 32'h300 || i_ready !== 1'b0) begin
        n_fail++; $display("FAIL mul_hold_%0d: got valid=%b pc=%h ready=%b, required 10000 300 0", c, o_valid, o_pc, i_ready);
      end
      step();
    end
    o_ready = 5'h1f;
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b10000 || i_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_fire: got valid=%b ready=%b, required 10000 1", o_valid, i_ready);
    end
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b00001 || o_pc !== 32'h304) begin
      n_fail++; $display("FAIL mul_next: got valid=%b pc=%h, required 00001 304", o_valid, o_pc);
    end
    step(); wbck_valid = 1'b1; wbck_rd = 5'd7;
    step(); wbck_rd = 5'd11;
    step(); wbck_valid = 1'b0;
  endtask

  task automatic test_illegal();
    step(); send(32'h400, c_op_alu, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b01000 || o_ilgl !== 1'b1 || o_rdwen !== 1'b0) begin
      n_fail++; $display("FAIL ilgl_flag: got valid=%b ilgl=%b rdwen=%b, required 01000 1 0", o_valid, o_ilgl, o_rdwen);
    end
    step(); probe(5'd9, busy);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ilgl_pend9: got busy=%b, required 0", busy); end
    step(); send(32'h404, c_op_bad, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b01000 || o_ilgl !== 1'b1 || o_rdwen !== 1'b0) begin
      n_fail++; $display("FAIL ilgl_badop: got valid=%b ilgl=%b rdwen=%b, required 01000 1 0", o_valid, o_ilgl, o_rdwen);
    end
    step(); probe(5'd12, busy);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ilgl_pend12: got busy=%b, required 0", busy); end
  endtask

  task automatic test_flush();
    o_ready = 5'b00000;
    step(); send(32'h500, c_op_bjp, 5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b00010) begin n_fail++; $display("FAIL flush_held: got %b, required 00010", o_valid); end
    step();
    send(32'h504, c_op_alu, 5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    flush = 1'b1; o_ready = 5'h1f;
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b, required 0", i_ready); end
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 00000", o_valid); end
    step(); probe(5'd1, busy);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_pend1: got busy=%b, required 0", busy); end
    step(); probe(5'd13, busy);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_pend13: got busy=%b, required 0", busy); end
  endtask

  task automatic test_wb_collision();
    step(); send(32'h600, c_op_alu, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    wbck_valid = 1'b1; wbck_rd = 5'd6;
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b00001 || o_rd !== 5'd6) begin
      n_fail++; $display("FAIL coll_dispatch: got valid=%b rd=%0d, required 00001 6", o_valid, o_rd);
    end
    step(); probe(5'd6, busy);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL coll_pend6: got busy=%b, required 1", busy); end
    step(); wbck_valid = 1'b1; wbck_rd = 5'd6;
    step(); wbck_valid = 1'b0;
    step(); send(32'h604, c_op_alu, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b1) begin n_fail++; $display("FAIL x0_first: got ready=%b, required 1", i_ready); end
    step(); send(32'h608, c_op_alu, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b1 || o_rd !== 5'd0 || o_rdwen !== 1'b1) begin
      n_fail++; $display("FAIL x0_hazard: got ready=%b rd=%0d rdwen=%b, required 1 0 1", i_ready, o_rd, o_rdwen);
    end
    step(); idle_in();
    @(negedge clock);
    n_checks++;
    if (o_stall_cnt !== exp_stall) begin n_fail++; $display("FAIL x0_stall: got %0d, required %0d", o_stall_cnt, exp_stall); end
  endtask

  task automatic test_reset_mid();
    o_ready = 5'b01111;
    step(); send(32'h700, c_op_mul, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    step(); send(32'h704, c_op_alu, 5'd10, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++;
    if (i_ready !== 1'b0) begin n_fail++; $display("FAIL mid_hazard: got ready=%b, required 0", i_ready); end
    step(); reset = 1'b1;
    exp_stall = exp_stall + 32'd1;
    @(negedge clock);
    n_checks++;
    if (o_stall_cnt !== exp_stall) begin n_fail++; $display("FAIL mid_stall_pre: got %0d, required %0d", o_stall_cnt, exp_stall); end
    step(); reset = 1'b0; idle_in(); o_ready = 5'h1f;
    exp_stall = 32'd0;
    @(negedge clock);
    n_checks++;
    if (o_valid !== 5'b0 || o_stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b stall=%0d, required 00000 0", o_valid, o_stall_cnt);
    end
    step(); probe(5'd10, busy);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_pend10: got busy=%b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw_stall();
    test_mul_backpressure();
    test_illegal();
    test_flush();
    test_wb_collision();
    test_reset_mid();
    repeat (3) step();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries left, required 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
